mc_main_control: RTL and testbench

- Multi-cycle main control FSM for the MIPS-subset datapath.
- Sequences each instruction through its fetch, decode, execute, memory and writeback steps.
- Drives the datapath mux selects and write enables.
- Generates the split ALUOp1/ALUOp2 pair consumed by the ALU-control decoder. It is the issuing end of that interface.
- Stalls in memory states on a single-bit memory ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 36 +++
 rtl/mc_main_control.sv | 136 +++++++++++++
 tb/tb_mc_main_control.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcodes, state codes and select encodings for the main control FSM
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC     = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle MIPS-subset main control FSM
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter bit ADDI_EN = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ALUOp1,
    output logic               ALUOp2,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign state_dbg = STATE_W'(state);

    always_comb begin
        state_nxt     = ST_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RT;
        ALUOp1        = 1'b0;
        ALUOp2        = 1'b0;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        unique case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                alu_src_b = ALUB_IMM_SH;
                if (opcode == OP_RTYPE)                        state_nxt = ST_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)   state_nxt = ST_MEM_ADDR;
                else if (opcode == OP_BEQ)                     state_nxt = ST_BRANCH;
                else if (opcode == OP_J)                       state_nxt = ST_JUMP;
                else if (ADDI_EN && opcode == OP_ADDI)         state_nxt = ST_ADDI_EX;
                else begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_nxt = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                state_nxt  = mem_ready ? ST_FETCH : ST_MEM_WR;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_RT;
                ALUOp1    = 1'b1;
                state_nxt = ST_R_WB;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                ALUOp2        = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_nxt = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            // IDLE and any unused code: all outputs low, fetch next
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - directed self-checking bench for mc_main_control
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ALUOp1, ALUOp2;
    logic       illegal_op, instr_done;
    logic [1:0] pc_source, alu_src_b;
    logic [3:0] state_dbg;

    logic       n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
    logic       n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_ALUOp1, n_ALUOp2;
    logic       n_illegal_op, n_instr_done;
    logic [1:0] n_pc_source, n_alu_src_b;
    logic [3:0] n_state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_main_control #(.ADDI_EN(1'b1), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp1(ALUOp1), .ALUOp2(ALUOp2),
        .illegal_op(illegal_op), .instr_done(instr_done), .state_dbg(state_dbg)
    );

    mc_main_control #(.ADDI_EN(1'b0), .STATE_W(4)) dut_na (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .pc_source(n_pc_source),
        .i_or_d(n_i_or_d), .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .mem_to_reg(n_mem_to_reg), .reg_dst(n_reg_dst), .reg_write(n_reg_write),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .ALUOp1(n_ALUOp1), .ALUOp2(n_ALUOp2),
        .illegal_op(n_illegal_op), .instr_done(n_instr_done), .state_dbg(n_state_dbg)
    );

    // {pw, pwc, psrc[1:0], iord, mr, mw, irw, m2r, rdst, rw, asa, asb[1:0], op1, op2, ill, done}
    logic [17:0] outs, n_outs;
    assign outs   = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp1, ALUOp2,
                     illegal_op, instr_done};
    assign n_outs = {n_pc_write, n_pc_write_cond, n_pc_source, n_i_or_d, n_mem_read, n_mem_write,
                     n_ir_write, n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_alu_src_b,
                     n_ALUOp1, n_ALUOp2, n_illegal_op, n_instr_done};

    //                                pw    pwc   psrc   iord  mr    mw    irw   m2r   rdst  rw    asa   asb    op1   op2   ill   done
    localparam logic [17:0] E_ZERO  = 18'd0;
    localparam logic [17:0] E_FWAIT = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_FRDY  = {1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_DEC   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_DILL  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [17:0] E_MADDR = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MRD   = {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MWB   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [17:0] E_MWRW  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_MWRD  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [17:0] E_EXEC  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_RWB   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [17:0] E_BR    = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [17:0] E_JMP   = {1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [17:0] E_AEX   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [17:0] E_AWB   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [3:0] st, input logic [17:0] o);
        #1;
        chk({tag, "/state"}, 32'(state_dbg), 32'(st));
        chk({tag, "/outs"}, 32'(outs), 32'(o));
    endtask

    task automatic look_na(input string tag, input logic [3:0] st, input logic [17:0] o);
        chk({tag, "/na_state"}, 32'(n_state_dbg), 32'(st));
        chk({tag, "/na_outs"}, 32'(n_outs), 32'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] o);
        look(tag, st, o);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        tick();
        tick();
        look("reset", 4'd0, E_ZERO);
        look_na("reset", 4'd0, E_ZERO);
        rst_n = 1'b1;
        cyc("idle", 4'd0, E_ZERO);

        // lw with two FETCH wait cycles, then memory ready everywhere
        opcode = 6'b100011;
        cyc("lw_fwait0", 4'd1, E_FWAIT);
        cyc("lw_fwait1", 4'd1, E_FWAIT);
        mem_ready = 1'b1;
        cyc("lw_fetch", 4'd1, E_FRDY);
        cyc("lw_dec", 4'd2, E_DEC);
        cyc("lw_maddr", 4'd3, E_MADDR);
        cyc("lw_mrd", 4'd4, E_MRD);
        cyc("lw_mwb", 4'd5, E_MWB);

        // sw with three MEM_WR wait cycles
        opcode = 6'b101011;
        cyc("sw_fetch", 4'd1, E_FRDY);
        cyc("sw_dec", 4'd2, E_DEC);
        mem_ready = 1'b0;
        cyc("sw_maddr", 4'd3, E_MADDR);
        cyc("sw_wait0", 4'd6, E_MWRW);
        cyc("sw_wait1", 4'd6, E_MWRW);
        cyc("sw_wait2", 4'd6, E_MWRW);
        mem_ready = 1'b1;
        cyc("sw_done", 4'd6, E_MWRD);

        opcode = 6'b000000;
        cyc("r_fetch", 4'd1, E_FRDY);
        cyc("r_dec", 4'd2, E_DEC);
        cyc("r_exec", 4'd7, E_EXEC);
        cyc("r_wb", 4'd8, E_RWB);

        opcode = 6'b000100;
        cyc("beq_fetch", 4'd1, E_FRDY);
        cyc("beq_dec", 4'd2, E_DEC);
        cyc("beq_br", 4'd9, E_BR);

        opcode = 6'b000010;
        cyc("j_fetch", 4'd1, E_FRDY);
        cyc("j_dec", 4'd2, E_DEC);
        cyc("j_jump", 4'd10, E_JMP);

        opcode = 6'b111111;
        cyc("ill_fetch", 4'd1, E_FRDY);
        look("ill_dec", 4'd2, E_DILL);
        look_na("ill_dec", 4'd2, E_DILL);
        tick();

        // addi: enabled instance executes it, disabled instance flags it illegal
        opcode = 6'b001000;
        look("addi_fetch", 4'd1, E_FRDY);
        look_na("addi_fetch", 4'd1, E_FRDY);
        tick();
        look("addi_dec", 4'd2, E_DEC);
        look_na("addi_dec", 4'd2, E_DILL);
        tick();
        look("addi_ex", 4'd11, E_AEX);
        look_na("addi_refetch", 4'd1, E_FRDY);
        tick();
        cyc("addi_wb", 4'd12, E_AWB);

        // reset asserted while stalled in MEM_RD
        opcode = 6'b100011;
        cyc("rst_fetch", 4'd1, E_FRDY);
        cyc("rst_dec", 4'd2, E_DEC);
        mem_ready = 1'b0;
        cyc("rst_maddr", 4'd3, E_MADDR);
        cyc("rst_mrd0", 4'd4, E_MRD);
        look("rst_mrd1", 4'd4, E_MRD);
        #2;
        rst_n = 1'b0;
        look("rst_async", 4'd0, E_ZERO);
        tick();
        look("rst_held", 4'd0, E_ZERO);
        rst_n = 1'b1;
        cyc("rst_idle", 4'd0, E_ZERO);
        look("rst_fetch2", 4'd1, E_FWAIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
